// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one 32-bit ALU among NUM_REQ requesters.
// Each operation runs IDLE (grant) -> EXEC (capture result) -> RESP (hold until accepted).
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [3*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [2:0]             alu_control,
    input  logic [31:0]            alu_result,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_data,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [31:0]          alu_a_q, alu_a_d;
    logic [31:0]          alu_b_q, alu_b_d;
    logic [2:0]           alu_ctl_q, alu_ctl_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [31:0]          resp_data_q, resp_data_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;

    // Search descends so the candidate closest to rr_ptr (k = 0) is assigned last and wins.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctl_d    = alu_ctl_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready = NUM_REQ'(1) << win_idx;
                    alu_a_d   = req_a[32*win_idx +: 32];
                    alu_b_d   = req_b[32*win_idx +: 32];
                    alu_ctl_d = req_op[3*win_idx +: 3];
                    win_d     = win_idx;
                    rr_ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_data_d  = alu_result;
                resp_valid_d = NUM_REQ'(1) << win_q;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready[win_q]) begin
                    resp_valid_d = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctl_q    <= 3'b000;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctl_q    <= alu_ctl_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctl_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign busy        = (state_q != S_IDLE);

endmodule
